bram_port_arbiter: RTL

- Shares one single-ported Xilinx BRAM port between two native requesters.
- Requester 0 is the AXI BRAM controller side; requester 1 is the debug/boot-loader write path.
- Sits between the requesters and the BRAM primitive.
- Round-robin arbitration, optional burst lock with timeout, and read-data return routed to the requester that issued the read.

---
 rtl/bram_port_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: round-robin share of one BRAM port between two requesters with burst lock and timeout
// Ports: clk_i/rst_ni clock and async active-low reset; mX_req/lock/we/addr/wdata requester beats,
// mX_gnt_o beat accepted, mX_rvalid_o/mX_rdata_o read return; bram_*_a drive the BRAM primitive port.
// Define BRAM_ARB_RDATA_REG_EN to register read data (2-cycle read latency instead of 1).
module bram_port_arbiter #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 13,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    m0_req_i,
  output logic                    m0_gnt_o,
  input  logic                    m0_lock_i,
  input  logic [DATA_WIDTH/8-1:0] m0_we_i,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  output logic                    m0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  input  logic                    m1_req_i,
  output logic                    m1_gnt_o,
  input  logic                    m1_lock_i,
  input  logic [DATA_WIDTH/8-1:0] m1_we_i,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  output logic                    m1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  output logic                    bram_en_a,
  output logic [DATA_WIDTH/8-1:0] bram_we_a,
  output logic [ADDR_WIDTH-1:0]   bram_addr_a,
  output logic [DATA_WIDTH-1:0]   bram_wrdata_a,
  input  logic [DATA_WIDTH-1:0]   bram_rddata_a
);
  localparam int BW = DATA_WIDTH / 8;
  localparam int CW = LOCK_TIMEOUT > 0 ? $clog2(LOCK_TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {UNLOCKED, LOCK0, LOCK1} state_t;
  state_t state, state_nxt;
  logic last_grant, last_grant_nxt;
  logic [CW-1:0] tcnt, tcnt_nxt;
  logic timed_out, open_arb, gnt0, gnt1, any_gnt, sel, sel_lock, rd_beat;
  logic [BW-1:0] sel_we;
  logic rv0, rid0, rv_out, rid_out;
  logic [DATA_WIDTH-1:0] rdata_out;
  // an expired lock behaves as unlocked in the same cycle, with the owner as last_grant
  assign timed_out = (LOCK_TIMEOUT != 0) && (tcnt == CW'(LOCK_TIMEOUT));
  always_comb begin
    open_arb       = state == UNLOCKED || timed_out;
    gnt0           = open_arb ? m0_req_i && (!m1_req_i || last_grant) : state == LOCK0 && m0_req_i;
    gnt1           = open_arb ? m1_req_i && (!m0_req_i || !last_grant) : state == LOCK1 && m1_req_i;
    any_gnt        = gnt0 || gnt1;
    sel            = gnt1 ? 1'b1 : gnt0 ? 1'b0 : last_grant;
    sel_lock       = sel ? m1_lock_i : m0_lock_i;
    sel_we         = sel ? m1_we_i : m0_we_i;
    rd_beat        = any_gnt && sel_we == '0;
    last_grant_nxt = any_gnt ? sel : last_grant;
    state_nxt      = any_gnt ? (sel_lock ? (sel ? LOCK1 : LOCK0) : UNLOCKED) : open_arb ? UNLOCKED : state;
    tcnt_nxt       = (open_arb || any_gnt || LOCK_TIMEOUT == 0) ? '0 : tcnt + 1'b1;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state      <= UNLOCKED;
      last_grant <= 1'b1;
      tcnt       <= '0;
      rv0        <= 1'b0;
      rid0       <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      tcnt       <= tcnt_nxt;
      rv0        <= rd_beat;
      rid0       <= sel;
    end
`ifdef BRAM_ARB_RDATA_REG_EN
  logic rv1, rid1;
  logic [DATA_WIDTH-1:0] rdata_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      rv1     <= 1'b0;
      rid1    <= 1'b0;
      rdata_q <= '0;
    end else begin
      rv1     <= rv0;
      rid1    <= rid0;
      rdata_q <= bram_rddata_a;
    end
  assign rv_out    = rv1;
  assign rid_out   = rid1;
  assign rdata_out = rdata_q;
`else
  assign rv_out    = rv0;
  assign rid_out   = rid0;
  assign rdata_out = bram_rddata_a;
`endif
  assign m0_gnt_o      = gnt0;
  assign m1_gnt_o      = gnt1;
  assign bram_en_a     = any_gnt;
  assign bram_we_a     = any_gnt ? sel_we : '0;
  assign bram_addr_a   = sel ? m1_addr_i : m0_addr_i;
  assign bram_wrdata_a = sel ? m1_wdata_i : m0_wdata_i;
  assign m0_rvalid_o   = rv_out && !rid_out;
  assign m1_rvalid_o   = rv_out && rid_out;
  assign m0_rdata_o    = rdata_out;
  assign m1_rdata_o    = rdata_out;
endmodule
